video_mem_arbiter: RTL
======================

VIDEO_MEM_ARBITER -- requirements
Module: video_mem_arbiter

Interface
REQ-001 SHALL have parameter WORDS_PER_LINE, default 100: 16-bit words fetched per visible line.
REQ-002 SHALL have parameter VIDEO_BASE, default 18'h00000: word address of line 0.
REQ-003 SHALL have port clk40, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port lineEnding, input, 1: one-cycle pulse announcing that the next line's fetch may start.
REQ-006 SHALL have port nextFrameActive, input, 1: the next line is visible; sampled with lineEnding.
REQ-007 SHALL have port nextVPos, input, 10: index of the next line; sampled with lineEnding.
REQ-008 SHALL have port cpu_req, input, 1: CPU access request, held high until cpu_ack.
REQ-009 SHALL have port cpu_we, input, 1: 1 = write, 0 = read; stable while cpu_req is high.
REQ-010 SHALL have port cpu_addr, input, 18: CPU word address.
REQ-011 SHALL have port cpu_wdata, input, 16: CPU write data.
REQ-012 SHALL have port cpu_ack, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port cpu_rdata, output, 16: read data, valid when cpu_ack is high.
REQ-014 SHALL have port mem_addr, output, 18: memory word address.
REQ-015 SHALL have port mem_oe, output, 1: read strobe; mem_rdata is valid on the next cycle.
REQ-016 SHALL have port mem_we, output, 1: write strobe.
REQ-017 SHALL have port mem_wdata, output, 16: memory write data.
REQ-018 SHALL have port mem_rdata, input, 16: memory read data.
REQ-019 SHALL have port fifo_full, input, 1: pixel FIFO almost-full; the FIFO can absorb one more write.
REQ-020 SHALL have port fifo_wr, output, 1: pixel FIFO write strobe.
REQ-021 SHALL have port fifo_data, output, 16: pixel FIFO write data.
REQ-022 SHALL have port fetch_overrun, output, 1: sticky error flag.

Function
REQ-023 SHALL implement states IDLE, VID_FETCH, CPU_ACC and CPU_ACK.
REQ-024 SHALL, on lineEnding with nextFrameActive=1, latch line address = VIDEO_BASE + nextVPos*WORDS_PER_LINE, modulo 2^18, and set fetch_pending.
REQ-025 SHALL ignore lineEnding when nextFrameActive=0.
REQ-026 SHALL, in IDLE, enter VID_FETCH if fetch_pending is set; otherwise enter CPU_ACC if cpu_req is high; video has strict priority when both are pending.
REQ-027 SHALL clear fetch_pending on entry to VID_FETCH.
REQ-028 SHALL, in VID_FETCH, issue one read per cycle while fifo_full=0:
- mem_oe=1, mem_addr = line address + word count;
- increment the word count after each issue;
- stall (mem_oe=0, no increment) while fifo_full=1.
REQ-029 SHALL assert fifo_wr exactly one cycle after each issued video read, with fifo_data = mem_rdata, independent of the current state.
REQ-030 SHALL return to IDLE after the WORDS_PER_LINE-th issue, making exactly WORDS_PER_LINE fifo_wr pulses per fetch.
REQ-031 SHALL, in CPU_ACC (one cycle), drive mem_addr=cpu_addr:
- read: mem_oe=1;
- write: mem_we=1, mem_wdata=cpu_wdata.
REQ-032 SHALL, in CPU_ACK (one cycle), pulse cpu_ack and, for a read, present cpu_rdata = mem_rdata, held until the next CPU read; then return to IDLE.
REQ-033 SHALL never preempt a CPU access; a lineEnding during CPU_ACC/CPU_ACK is held in fetch_pending and served from the next IDLE.
REQ-034 SHALL, if lineEnding (with nextFrameActive=1) arrives while in VID_FETCH or while fetch_pending is already set, drop the new request, keep the current fetch, and set fetch_overrun.
REQ-035 SHALL keep fetch_overrun set until reset.
REQ-036 SHALL hold mem_oe=0 and mem_we=0 in IDLE and never assert both strobes in the same cycle.
REQ-037 SHALL serve a cpu_req still high after cpu_ack, in IDLE, as a new transaction.

Reset
REQ-038 SHALL, while reset is high, force state=IDLE, with:
- fetch_pending, word count, cpu_ack, mem_oe, mem_we, fifo_wr and fetch_overrun = 0;
- mem_addr, mem_wdata, cpu_rdata and fifo_data = 0.
REQ-039 SHALL abandon any fetch in progress when reset occurs mid-operation, with no fifo_wr after reset is asserted.

Verification
REQ-040 SHALL cover: lineEnding, nextVPos=5, fifo_full=0 -> 100 consecutive reads at addresses 500..599, and 100 fifo_wr pulses one cycle later carrying the memory data.
REQ-041 SHALL cover: fifo_full high for 3 cycles mid-burst -> 3 cycles of mem_oe=0 with the address frozen, and the total fifo_wr count still 100.
REQ-042 SHALL cover: cpu_req read at 0x12345 with lineEnding in the same cycle -> the video fetch runs first; CPU_ACC follows, and cpu_ack is issued 2 cycles after the burst ends with the correct rdata.
REQ-043 SHALL cover: CPU write in progress when lineEnding arrives -> the write completes (mem_we for 1 cycle, then cpu_ack), then the fetch starts from IDLE.
REQ-044 SHALL cover: a second lineEnding during VID_FETCH -> fetch_overrun=1, exactly 100 words fetched, and the flag persisting until reset.
REQ-045 SHALL cover: reset asserted at word 40 -> all outputs 0 immediately, IDLE after release, and no further fifo_wr.

Source files
------------

// File: rtl/video_mem_arbiter.sv
// Video memory arbiter: shares one 16-bit word-addressed memory between the
// line-buffer video fetch and a CPU port.
//   clk40, reset              : single clock, asynchronous active-high reset
//   lineEnding/nextFrameActive/nextVPos : request a fetch of the next line
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_ack/cpu_rdata : CPU handshake
//   mem_addr/mem_oe/mem_we/mem_wdata, mem_rdata : memory (read data one cycle
//                                                 after mem_oe)
//   fifo_full -> fifo_wr/fifo_data : pixel FIFO write side
//   fetch_overrun             : sticky, a line request arrived while busy
module video_mem_arbiter #(
    parameter int unsigned WORDS_PER_LINE = 100,
    parameter logic [17:0] VIDEO_BASE     = 18'h00000
) (
    input  logic        clk40,
    input  logic        reset,
    input  logic        lineEnding,
    input  logic        nextFrameActive,
    input  logic [9:0]  nextVPos,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [17:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    output logic [17:0] mem_addr,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        fifo_full,
    output logic        fifo_wr,
    output logic [15:0] fifo_data,
    output logic        fetch_overrun
);

    localparam int unsigned CountWidth = $clog2(WORDS_PER_LINE + 1);
    localparam logic [CountWidth-1:0] LastWord = CountWidth'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {StIdle, StVidFetch, StCpuAcc, StCpuAck} state_t;

    state_t                stateQ, stateD;
    logic                  fetchPendingQ, fetchPendingD;
    logic [CountWidth-1:0] wordCountQ, wordCountD;
    logic [17:0]           lineAddrQ, lineAddrD;
    logic                  overrunQ, overrunD;
    logic                  cpuWeQ, cpuWeD;
    logic [15:0]           rdataQ, rdataD;
    logic                  fifoWrQ;
    logic                  issue;

    logic [17:0] lineOffset, lineBase;
    logic        newLine, busy, accept;

    // Line start address wraps modulo 2^18 by truncation.
    assign lineOffset = 18'(32'(nextVPos) * WORDS_PER_LINE);
    assign lineBase   = VIDEO_BASE + lineOffset;

    assign newLine = lineEnding & nextFrameActive;
    // A fetch is either running or already queued; a further request is dropped.
    assign busy    = (stateQ == StVidFetch) | fetchPendingQ;
    assign accept  = newLine & ~busy;

    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            stateQ        <= StIdle;
            fetchPendingQ <= 1'b0;
            wordCountQ    <= '0;
            lineAddrQ     <= '0;
            overrunQ      <= 1'b0;
            cpuWeQ        <= 1'b0;
            rdataQ        <= '0;
            fifoWrQ       <= 1'b0;
        end else begin
            stateQ        <= stateD;
            fetchPendingQ <= fetchPendingD;
            wordCountQ    <= wordCountD;
            lineAddrQ     <= lineAddrD;
            overrunQ      <= overrunD;
            cpuWeQ        <= cpuWeD;
            rdataQ        <= rdataD;
            fifoWrQ       <= issue;
        end
    end

    always_comb begin
        stateD        = stateQ;
        fetchPendingD = fetchPendingQ;
        wordCountD    = wordCountQ;
        lineAddrD     = lineAddrQ;
        overrunD      = overrunQ | (newLine & busy);
        cpuWeD        = cpuWeQ;
        rdataD        = rdataQ;
        issue         = 1'b0;
        cpu_ack       = 1'b0;
        mem_addr      = '0;
        mem_oe        = 1'b0;
        mem_we        = 1'b0;
        mem_wdata     = '0;

        if (accept) begin
            lineAddrD = lineBase;
        end

        case (stateQ)
            StIdle: begin
                // Video wins over the CPU, including a request arriving this cycle.
                if (fetchPendingQ || accept) begin
                    stateD        = StVidFetch;
                    fetchPendingD = 1'b0;
                    wordCountD    = '0;
                end else if (cpu_req) begin
                    stateD = StCpuAcc;
                    cpuWeD = cpu_we;
                end
            end
            StVidFetch: begin
                mem_addr = lineAddrQ + 18'(wordCountQ);
                if (!fifo_full) begin
                    mem_oe = 1'b1;
                    issue  = 1'b1;
                    if (wordCountQ == LastWord) begin
                        stateD     = StIdle;
                        wordCountD = '0;
                    end else begin
                        wordCountD = wordCountQ + 1'b1;
                    end
                end
            end
            StCpuAcc: begin
                mem_addr = cpu_addr;
                if (cpuWeQ) begin
                    mem_we    = 1'b1;
                    mem_wdata = cpu_wdata;
                end else begin
                    mem_oe = 1'b1;
                end
                stateD = StCpuAck;
                if (accept) fetchPendingD = 1'b1;
            end
            StCpuAck: begin
                cpu_ack = 1'b1;
                if (!cpuWeQ) rdataD = mem_rdata;
                stateD = StIdle;
                if (accept) fetchPendingD = 1'b1;
            end
            default: stateD = StIdle;
        endcase
    end

    // Read data is passed through during the ack cycle and then held.
    assign cpu_rdata     = rdataD;
    assign fifo_wr       = fifoWrQ;
    assign fifo_data     = fifoWrQ ? mem_rdata : 16'h0000;
    assign fetch_overrun = overrunQ;

endmodule
